// File: rtl/cash_dispense_ctrl.sv
// Note-dispenser sequencer: plans a 500/100 mix against cassette stock, then fires notes one at a time.
// Optional audit counters (total_dispensed, txn_count) are built only when DISP_AUDIT_EN is defined.
module cash_dispense_ctrl #(
   parameter int B_WIDTH     = 20,
   parameter int N_WIDTH     = 10,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic [B_WIDTH-1:0] amount,
   input  logic               refill,
   input  logic [N_WIDTH-1:0] refill_n500,
   input  logic [N_WIDTH-1:0] refill_n100,
   input  logic               note_ack,
   input  logic               note_fault,
   output logic               note_fire,
   output logic               note_sel,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [1:0]         err_code,
   output logic [N_WIDTH-1:0] n500_left,
   output logic [N_WIDTH-1:0] n100_left,
   output logic [B_WIDTH-1:0] dispensed_value
`ifdef DISP_AUDIT_EN
   ,
   output logic [31:0]        total_dispensed,
   output logic [15:0]        txn_count
`endif
);

   localparam int T_WIDTH = $clog2(ACK_TIMEOUT + 1);
   localparam logic [B_WIDTH-1:0] VAL_500  = B_WIDTH'(500);
   localparam logic [B_WIDTH-1:0] VAL_100  = B_WIDTH'(100);
   localparam logic [T_WIDTH-1:0] TMO_LAST = T_WIDTH'(ACK_TIMEOUT - 1);
   localparam logic [1:0] EC_NONE   = 2'd0;
   localparam logic [1:0] EC_AMOUNT = 2'd1;
   localparam logic [1:0] EC_NOTES  = 2'd2;
   localparam logic [1:0] EC_JAM    = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_PLAN, S_FIRE, S_GAP, S_DONE, S_ERR} state_t;

   state_t             state, state_nx;
   logic [B_WIDTH-1:0] rem, rem_nx;
   logic [N_WIDTH-1:0] p500, p500_nx;
   logic [N_WIDTH-1:0] p100, p100_nx;
   logic [N_WIDTH-1:0] n500_nx, n100_nx;
   logic [B_WIDTH-1:0] dv_nx;
   logic [1:0]         ec_nx;
   logic [T_WIDTH-1:0] tmo_cnt, tmo_nx;
   logic [B_WIDTH-1:0] add_val;

   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      p500_nx  = p500;
      p100_nx  = p100;
      n500_nx  = n500_left;
      n100_nx  = n100_left;
      dv_nx    = dispensed_value;
      ec_nx    = err_code;
      tmo_nx   = tmo_cnt;
      add_val  = '0;
      unique case (state)
         S_IDLE: begin
            // refill has priority; a coincident req is simply dropped
            if (refill) begin
               n500_nx = refill_n500;
               n100_nx = refill_n100;
            end else if (req) begin
               if (amount == '0) begin
                  state_nx = S_ERR;
                  ec_nx    = EC_AMOUNT;
               end else begin
                  state_nx = S_PLAN;
                  rem_nx   = amount;
                  p500_nx  = '0;
                  p100_nx  = '0;
                  dv_nx    = '0;
                  ec_nx    = EC_NONE;
               end
            end
         end
         S_PLAN: begin
            if (rem >= VAL_500 && p500 < n500_left) begin
               rem_nx  = rem - VAL_500;
               p500_nx = p500 + N_WIDTH'(1);
            end else if (rem >= VAL_100 && p100 < n100_left) begin
               rem_nx  = rem - VAL_100;
               p100_nx = p100 + N_WIDTH'(1);
            end else if (rem == '0) begin
               state_nx = S_FIRE;
               tmo_nx   = '0;
            end else if (rem < VAL_100) begin
               state_nx = S_ERR;
               ec_nx    = EC_AMOUNT;
            end else begin
               state_nx = S_ERR;
               ec_nx    = EC_NOTES;
            end
         end
         S_FIRE: begin
            // a fault in the same cycle as an ack voids that note
            if (note_fault) begin
               state_nx = S_ERR;
               ec_nx    = EC_JAM;
            end else if (note_ack) begin
               state_nx = S_GAP;
               if (p500 != '0) begin
                  p500_nx = p500 - N_WIDTH'(1);
                  n500_nx = n500_left - N_WIDTH'(1);
                  add_val = VAL_500;
               end else begin
                  p100_nx = p100 - N_WIDTH'(1);
                  n100_nx = n100_left - N_WIDTH'(1);
                  add_val = VAL_100;
               end
               dv_nx = dispensed_value + add_val;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nx = S_ERR;
               ec_nx    = EC_JAM;
            end else begin
               tmo_nx = tmo_cnt + T_WIDTH'(1);
            end
         end
         S_GAP: begin
            if (p500 != '0 || p100 != '0) begin
               state_nx = S_FIRE;
               tmo_nx   = '0;
            end else begin
               state_nx = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they align with the state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         rem             <= '0;
         p500            <= '0;
         p100            <= '0;
         n500_left       <= '0;
         n100_left       <= '0;
         dispensed_value <= '0;
         err_code        <= EC_NONE;
         tmo_cnt         <= '0;
         note_fire       <= 1'b0;
         note_sel        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         state           <= state_nx;
         rem             <= rem_nx;
         p500            <= p500_nx;
         p100            <= p100_nx;
         n500_left       <= n500_nx;
         n100_left       <= n100_nx;
         dispensed_value <= dv_nx;
         err_code        <= ec_nx;
         tmo_cnt         <= tmo_nx;
         note_fire       <= (state_nx == S_FIRE);
         note_sel        <= (state_nx == S_FIRE) && (p500_nx != '0);
         busy            <= (state_nx != S_IDLE);
         done            <= (state_nx == S_DONE);
         error           <= (state_nx == S_ERR);
      end
   end

`ifdef DISP_AUDIT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_dispensed <= '0;
         txn_count       <= '0;
      end else begin
         total_dispensed <= total_dispensed + 32'(add_val);
         if (state == S_DONE) begin
            txn_count <= txn_count + 16'd1;
         end
      end
   end
`endif

endmodule
